ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 rs1_data_d2, rs2_data_d2  in  64 each  register operands from the ID/EX register.
REQ-005 rs1_d2, rs2_d2, rd_d2  in  5 each  source and destination register indices.
REQ-006 immediate_d2, pc_d2  in  64 each  sign-extended immediate; instruction PC.
REQ-007 branch_d2, mem_read_d2, mem_to_reg_d2, mem_write_d2, alu_src_d2, reg_write_d2  in  1 each  control bits.
REQ-008 alu_op_d2  in  2  ALU class; func3_d2  in  3; func7b5_d2  in  1.
REQ-009 exmem_rd  in  5; exmem_reg_write  in  1; exmem_alu_result  in  64  EX/MEM forwarding source.
REQ-010 memwb_rd  in  5; memwb_reg_write  in  1; memwb_data  in  64  MEM/WB forwarding source.
REQ-011 stall, flush  in  1 each  hold request; bubble-insert request.
REQ-012 alu_result_d3, store_data_d3, branch_target_d3  out  64 each  registered results.
REQ-013 rd_d3  out  5; reg_write_d3, mem_read_d3, mem_write_d3, mem_to_reg_d3, branch_taken_d3, zero_d3  out  1 each  registered.

Function
REQ-014 Operand A SHALL be exmem_alu_result when exmem_reg_write, exmem_rd!=0 and exmem_rd==rs1_d2; else memwb_data when memwb_reg_write, memwb_rd!=0 and memwb_rd==rs1_d2; else rs1_data_d2.
REQ-015 Forwarded B SHALL use the REQ-014 rule against rs2_d2; EX/MEM always has priority over MEM/WB.
REQ-016 ALU input B SHALL be immediate_d2 when alu_src_d2=1, else forwarded B; store_data SHALL always be forwarded B.
REQ-017 alu_op 00: add; 01: subtract.
REQ-018 alu_op 10 (R-type) by func3: 000 add, or sub if func7b5; 001 sll; 010 slt signed; 100 xor; 101 srl, or sra if func7b5; 110 or; 111 and.
REQ-019 alu_op 11 (I-type): as REQ-018 except that func3 000 is always add.
REQ-020 Shifts SHALL use B[5:0]; add and sub SHALL wrap modulo 2^64; slt SHALL yield 64'd1 or 64'd0.
REQ-021 zero SHALL be 1 when the 64-bit ALU result is 0.
REQ-022 Branches SHALL compare operand A against forwarded B.
REQ-023 branch_taken SHALL be branch_d2 AND the func3 condition: 000 equal; 001 not equal; 100 signed less-than; 101 signed greater-or-equal; 110 unsigned less-than; 111 unsigned greater-or-equal; any other func3 gives 0.
REQ-024 branch_target SHALL be pc_d2 + immediate_d2, modulo 2^64.
REQ-025 Latency: every _d3 output SHALL update one clk edge after its inputs are presented.
REQ-026 With stall=1 and flush=0, all _d3 outputs SHALL hold their values.
REQ-027 flush=1 SHALL clear reg_write_d3, mem_read_d3, mem_write_d3, mem_to_reg_d3 and branch_taken_d3 to 0 while all other _d3 outputs capture normally.
REQ-028 When stall and flush are both 1, flush SHALL win.
REQ-029 rd_d2=0 SHALL still propagate; reg_write_d3 passes through unchanged.

Reset
REQ-030 rst_n=0 SHALL drive every output to 0 immediately, independent of clk.
REQ-031 Release of rst_n SHALL take effect at the first rising clk edge after deassertion; assertion mid-operation SHALL discard any in-flight result.

Verification
REQ-032 R-type sub: rs1=10, rs2=3, alu_op=10, func3=000, func7b5=1 -> alu_result_d3=7, zero_d3=0 after one edge.
REQ-033 Forwarding priority: rs1_d2=5, exmem_rd=5 with result 100, memwb_rd=5 with data 200, both write-enables 1, add with immediate 1 -> alu_result_d3=101; with exmem_reg_write=0 -> 201.
REQ-034 x0 guard: rs1_d2=0, exmem_rd=0, exmem_reg_write=1, rs1_data_d2=0 -> operand A is 0 and is not forwarded.
REQ-035 Branch: beq with both operands 42 and branch_d2=1, pc=0x100, imm=0x20 -> branch_taken_d3=1, branch_target_d3=0x120; bne with the same inputs -> branch_taken_d3=0.
REQ-036 Stall then flush: stall held 3 cycles -> outputs unchanged; then stall=1 and flush=1 together with reg_write_d2=1 -> reg_write_d3=0.
REQ-037 Async reset: pulse rst_n low between clk edges -> all outputs read 0 before the next edge.

Source files
------------

// File: rtl/ex_stage_if.sv
// Bundles the ID/EX operands and controls, the two forwarding sources, the
// stall/flush requests and the registered EX/MEM results of the execute stage.
interface ex_stage_if;
  logic [63:0] rs1_data_d2, rs2_data_d2, immediate_d2, pc_d2;
  logic [4:0]  rs1_d2, rs2_d2, rd_d2;
  logic        branch_d2, mem_read_d2, mem_to_reg_d2, mem_write_d2, alu_src_d2, reg_write_d2;
  logic [1:0]  alu_op_d2;
  logic [2:0]  func3_d2;
  logic        func7b5_d2;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [63:0] exmem_alu_result, memwb_data;
  logic        stall, flush;
  logic [63:0] alu_result_d3, store_data_d3, branch_target_d3;
  logic [4:0]  rd_d3;
  logic        reg_write_d3, mem_read_d3, mem_write_d3, mem_to_reg_d3, branch_taken_d3, zero_d3;

  modport slave (
    input  rs1_data_d2, rs2_data_d2, immediate_d2, pc_d2, rs1_d2, rs2_d2, rd_d2,
           branch_d2, mem_read_d2, mem_to_reg_d2, mem_write_d2, alu_src_d2, reg_write_d2,
           alu_op_d2, func3_d2, func7b5_d2, exmem_rd, memwb_rd, exmem_reg_write,
           memwb_reg_write, exmem_alu_result, memwb_data, stall, flush,
    output alu_result_d3, store_data_d3, branch_target_d3, rd_d3, reg_write_d3,
           mem_read_d3, mem_write_d3, mem_to_reg_d3, branch_taken_d3, zero_d3
  );

  modport master (
    output rs1_data_d2, rs2_data_d2, immediate_d2, pc_d2, rs1_d2, rs2_d2, rd_d2,
           branch_d2, mem_read_d2, mem_to_reg_d2, mem_write_d2, alu_src_d2, reg_write_d2,
           alu_op_d2, func3_d2, func7b5_d2, exmem_rd, memwb_rd, exmem_reg_write,
           memwb_reg_write, exmem_alu_result, memwb_data, stall, flush,
    input  alu_result_d3, store_data_d3, branch_target_d3, rd_d3, reg_write_d3,
           mem_read_d3, mem_write_d3, mem_to_reg_d3, branch_taken_d3, zero_d3
  );
endinterface

// File: rtl/ex_stage.sv
// RV64 execute stage: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register with stall/flush control.
module ex_stage (
  input  logic       clk,
  input  logic       rst_n,
  ex_stage_if.slave  bus
);
  logic [63:0] op_a, fwd_b, alu_b, alu_res;
  logic [5:0]  shamt;
  logic        br_cond, capture;

  logic [63:0] alu_result_q, alu_result_d, store_data_q, store_data_d, branch_target_q, branch_target_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d, branch_taken_q, branch_taken_d, zero_q, zero_d;

  // EX/MEM is checked first so the younger result wins; x0 is never forwarded.
  always_comb begin
    op_a = bus.rs1_data_d2;
    if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == bus.rs1_d2)
      op_a = bus.exmem_alu_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == bus.rs1_d2)
      op_a = bus.memwb_data;

    fwd_b = bus.rs2_data_d2;
    if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == bus.rs2_d2)
      fwd_b = bus.exmem_alu_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == bus.rs2_d2)
      fwd_b = bus.memwb_data;
  end

  assign alu_b = bus.alu_src_d2 ? bus.immediate_d2 : fwd_b;
  assign shamt = alu_b[5:0];

  always_comb begin
    alu_res = 64'd0;
    case (bus.alu_op_d2)
      2'b00: alu_res = op_a + alu_b;
      2'b01: alu_res = op_a - alu_b;
      default: begin
        case (bus.func3_d2)
          // I-type has no sub encoding, so func7b5 only matters for R-type.
          3'b000: alu_res = (bus.alu_op_d2 == 2'b10 && bus.func7b5_d2) ? op_a - alu_b : op_a + alu_b;
          3'b001: alu_res = op_a << shamt;
          3'b010: alu_res = ($signed(op_a) < $signed(alu_b)) ? 64'd1 : 64'd0;
          3'b100: alu_res = op_a ^ alu_b;
          3'b101: alu_res = bus.func7b5_d2 ? 64'($signed(op_a) >>> shamt) : op_a >> shamt;
          3'b110: alu_res = op_a | alu_b;
          3'b111: alu_res = op_a & alu_b;
          default: alu_res = 64'd0;
        endcase
      end
    endcase
  end

  always_comb begin
    case (bus.func3_d2)
      3'b000:  br_cond = (op_a == fwd_b);
      3'b001:  br_cond = (op_a != fwd_b);
      3'b100:  br_cond = ($signed(op_a) < $signed(fwd_b));
      3'b101:  br_cond = ($signed(op_a) >= $signed(fwd_b));
      3'b110:  br_cond = (op_a < fwd_b);
      3'b111:  br_cond = (op_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  // Flush overrides stall: data fields load normally, control bits become a bubble.
  assign capture = bus.flush || !bus.stall;

  always_comb begin
    alu_result_d    = alu_result_q;
    store_data_d    = store_data_q;
    branch_target_d = branch_target_q;
    rd_d            = rd_q;
    zero_d          = zero_q;
    reg_write_d     = reg_write_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    branch_taken_d  = branch_taken_q;
    if (capture) begin
      alu_result_d    = alu_res;
      store_data_d    = fwd_b;
      branch_target_d = bus.pc_d2 + bus.immediate_d2;
      rd_d            = bus.rd_d2;
      zero_d          = (alu_res == 64'd0);
      reg_write_d     = bus.reg_write_d2 && !bus.flush;
      mem_read_d      = bus.mem_read_d2 && !bus.flush;
      mem_write_d     = bus.mem_write_d2 && !bus.flush;
      mem_to_reg_d    = bus.mem_to_reg_d2 && !bus.flush;
      branch_taken_d  = bus.branch_d2 && br_cond && !bus.flush;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_q    <= 64'd0;
      store_data_q    <= 64'd0;
      branch_target_q <= 64'd0;
      rd_q            <= 5'd0;
      zero_q          <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      branch_taken_q  <= 1'b0;
    end else begin
      alu_result_q    <= alu_result_d;
      store_data_q    <= store_data_d;
      branch_target_q <= branch_target_d;
      rd_q            <= rd_d;
      zero_q          <= zero_d;
      reg_write_q     <= reg_write_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      branch_taken_q  <= branch_taken_d;
    end
  end

  assign bus.alu_result_d3    = alu_result_q;
  assign bus.store_data_d3    = store_data_q;
  assign bus.branch_target_d3 = branch_target_q;
  assign bus.rd_d3            = rd_q;
  assign bus.zero_d3          = zero_q;
  assign bus.reg_write_d3     = reg_write_q;
  assign bus.mem_read_d3      = mem_read_q;
  assign bus.mem_write_d3     = mem_write_q;
  assign bus.mem_to_reg_d3    = mem_to_reg_q;
  assign bus.branch_taken_d3  = branch_taken_q;
endmodule
